// File: rtl/ilkn_metaframe_ctrl.sv
// Interlaken TX lane metaframe sequencer.
// Builds Sync / Scrambler State / Skip / payload / Diagnostic words for the
// 64B/67B lane encoder. User words fill the payload slots. Idle control words
// fill any slot the user leaves empty. Every encoder-facing output is registered.
module ilkn_metaframe_ctrl #(
    parameter int unsigned META_LEN  = 2048,
    parameter logic [63:0] IDLE_WORD = 64'h8000_0000_0000_0000
) (
    input  logic        USER_CLK,
    input  logic        SYSTEM_RESET,
    input  logic        ENABLE,
    input  logic [63:0] TX_DATA,
    input  logic [1:0]  TX_HEADER,
    input  logic        TX_VALID,
    output logic        TX_READY,
    input  logic [57:0] SCRAMBLER_STATE,
    input  logic [1:0]  LANE_STATUS,
    output logic [63:0] ENC_DATA,
    output logic [1:0]  ENC_HEADER,
    output logic        ENC_PASSTHROUGH,
    output logic        META_START,
    output logic [15:0] META_CNT
);

    // The word counter is 16 bits wide, and a metaframe needs its four control words.
    if ((META_LEN < 5) || (META_LEN > 65535)) begin : g_meta_len_check
        $error("ilkn_metaframe_ctrl: META_LEN must be within 5..65535");
    end

    localparam logic [1:0]  HDR_CTRL   = 2'b10;
    localparam logic [63:0] SYNC_WORD  = 64'h78F6_78F6_78F6_78F6;
    localparam logic [63:0] SKIP_WORD  = 64'h1E1E_1E1E_1E1E_1E1E;
    localparam logic [5:0]  SCRAM_TAG  = 6'b001010;
    localparam logic [5:0]  DIAG_TAG   = 6'b011001;
    // Word-counter value of the final payload slot (Sync occupies index 0).
    localparam logic [15:0] LAST_SLOT  = 16'(META_LEN - 2);

    typedef enum logic [2:0] {
        StDisabled,
        StSync,
        StScram,
        StSkip,
        StPayload,
        StDiag
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] word_cnt_q, word_cnt_d;
    logic [15:0] meta_cnt_q, meta_cnt_d;
    logic [63:0] enc_data_q, enc_data_d;
    logic [1:0]  enc_header_q, enc_header_d;
    logic        enc_pass_q, enc_pass_d;
    logic        meta_start_q, meta_start_d;

    // Next-state, next-word and user handshake, decoded from the current state.
    always_comb begin
        state_d      = state_q;
        word_cnt_d   = word_cnt_q + 16'd1;
        meta_cnt_d   = meta_cnt_q;
        enc_data_d   = 64'h0;
        enc_header_d = HDR_CTRL;
        enc_pass_d   = 1'b0;
        meta_start_d = 1'b0;
        TX_READY     = 1'b0;

        unique case (state_q)
            StDisabled: begin
                word_cnt_d   = 16'd0;
                enc_header_d = 2'b00;
                enc_pass_d   = 1'b1;
                if (ENABLE) begin
                    state_d = StSync;
                end
            end
            StSync: begin
                enc_data_d   = SYNC_WORD;
                meta_start_d = 1'b1;
                state_d      = StScram;
            end
            StScram: begin
                enc_data_d = {SCRAM_TAG, SCRAMBLER_STATE};
                state_d    = StSkip;
            end
            StSkip: begin
                enc_data_d = SKIP_WORD;
                state_d    = StPayload;
            end
            StPayload: begin
                // A slot is consumed every cycle, even when it carries only an idle word.
                TX_READY = 1'b1;
                if (TX_VALID) begin
                    enc_header_d = TX_HEADER;
                    enc_data_d   = TX_DATA;
                end else begin
                    enc_data_d   = IDLE_WORD;
                end
                if (word_cnt_q == LAST_SLOT) begin
                    state_d = StDiag;
                end
            end
            StDiag: begin
                // CRC32 field is left zero; it is inserted further down the lane.
                enc_data_d = {DIAG_TAG, 24'h0, LANE_STATUS, 32'h0};
                meta_cnt_d = meta_cnt_q + 16'd1;
                word_cnt_d = 16'd0;
                state_d    = ENABLE ? StSync : StDisabled;
            end
            default: begin
                word_cnt_d   = 16'd0;
                enc_header_d = 2'b00;
                enc_pass_d   = 1'b1;
                state_d      = StDisabled;
            end
        endcase
    end

    // State, counters and encoder-facing output registers.
    always_ff @(posedge USER_CLK or posedge SYSTEM_RESET) begin
        if (SYSTEM_RESET) begin
            state_q      <= StDisabled;
            word_cnt_q   <= 16'd0;
            meta_cnt_q   <= 16'd0;
            enc_data_q   <= 64'h0;
            enc_header_q <= 2'b00;
            enc_pass_q   <= 1'b1;
            meta_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_cnt_q   <= word_cnt_d;
            meta_cnt_q   <= meta_cnt_d;
            enc_data_q   <= enc_data_d;
            enc_header_q <= enc_header_d;
            enc_pass_q   <= enc_pass_d;
            meta_start_q <= meta_start_d;
        end
    end

    assign ENC_DATA        = enc_data_q;
    assign ENC_HEADER      = enc_header_q;
    assign ENC_PASSTHROUGH = enc_pass_q;
    assign META_START      = meta_start_q;
    assign META_CNT        = meta_cnt_q;

endmodule
